// File: rtl/seven_seg_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit seven-segment display.
// Three requesters compete for the display. Each owner gets a minimum dwell
// before a competitor can take over, and the owner's digits are forwarded,
// registered, to the unchanged scanner that sits downstream.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; grant=0, displays show IDLE_VALUE
// OWNED | requester `owner` holds the display; dwell counter running
module seven_seg_arbiter #(
  parameter int          HOLD_COUNT = 10_000_000 - 1,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic        clk_10Mhz,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [3:0]  displayA,
  output logic [3:0]  displayB,
  output logic [3:0]  displayC,
  output logic [3:0]  displayD
);

  localparam int            CW     = $clog2(HOLD_COUNT + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_COUNT);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    owner, owner_nx;
  logic [1:0]    last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    own_mask;
  logic [15:0]   disp_nx;

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] rr_step(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First set request scanning p+1, p+2, then p itself. Callers only use the
  // result when some request bit is set.
  function automatic logic [1:0] rr_winner(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_step(p);
    c2 = rr_step(c1);
    if (r[c1])      return c1;
    else if (r[c2]) return c2;
    else            return p;
  endfunction

  // Next-state decision: release first, then dwell-expired preemption, else hold.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    own_mask = 3'b001 << owner;
    disp_nx  = IDLE_VALUE;

    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          owner_nx = rr_winner(req, last);
          last_nx  = owner_nx;
          cnt_nx   = '0;
          state_nx = OWNED;
        end
      end
      OWNED: begin
        if (!req[owner]) begin
          // The dwell is not enforced when the owner lets go.
          if ((req & ~own_mask) != 3'b000) begin
            owner_nx = rr_winner(req, owner);
            last_nx  = owner_nx;
            cnt_nx   = '0;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else if (cnt == HOLD_C && (req & ~own_mask) != 3'b000) begin
          owner_nx = rr_winner(req, owner);
          last_nx  = owner_nx;
          cnt_nx   = '0;
        end else if (cnt != HOLD_C) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Displays follow the next-state owner so a handoff carries new data
    // on the same edge as the new grant.
    if (state_nx == OWNED) begin
      case (owner_nx)
        2'd0:    disp_nx = data0;
        2'd1:    disp_nx = data1;
        default: disp_nx = data2;
      endcase
    end
  end

  // State, pointer, dwell counter and registered outputs.
  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 2'd0;
      last  <= 2'd2;
      cnt   <= '0;
      grant <= 3'b000;
      busy  <= 1'b0;
      {displayA, displayB, displayC, displayD} <= IDLE_VALUE;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      grant <= (state_nx == OWNED) ? (3'b001 << owner_nx) : 3'b000;
      busy  <= (state_nx == OWNED);
      {displayA, displayB, displayC, displayD} <= disp_nx;
    end
  end

endmodule

// File: doc/seven_seg_arbiter.md
# seven_seg_arbiter

Shares the 4-digit seven-segment display between three requesters (e.g. a clock/timer, a game score, a status source). It grants ownership round-robin, enforces a minimum dwell time per owner, and drives the `displayA`..`displayD` nibble inputs of the existing display scanner. The scanner itself is unchanged; this block sits directly upstream of it, on the same 10 MHz clock.

## Interface
Parameters:
- `HOLD_COUNT`, default 10_000_000-1: minimum dwell before an owner can be preempted, in clocks (1 s at 10 MHz). Legal range is ≥1.
- `IDLE_VALUE`, default 16'h0000: nibbles {A,B,C,D} driven when no one owns the display.

Ports (one clock; reset is synchronous and active-low):
- `clk_10Mhz`  in  1  system clock, 10 MHz.
- `reset_n`  in  1  synchronous reset, active-low.
- `req`  in  3  level request per requester; bit k belongs to requester k.
- `data0`  in  16  requester 0 digits: [15:12]=A, [11:8]=B, [7:4]=C, [3:0]=D.
- `data1`  in  16  requester 1 digits, same packing.
- `data2`  in  16  requester 2 digits, same packing.
- `grant`  out  3  one-hot current owner, or 0 when idle; registered.
- `busy`  out  1  high when `grant` != 0; registered.
- `displayA`  out  4  leftmost digit to scanner; registered.
- `displayB`  out  4  registered.
- `displayC`  out  4  registered.
- `displayD`  out  4  rightmost digit; registered.

## Operation
- Internal state:
  - FSM with two states, IDLE and OWNED.
  - Owner index `k`.
  - Dwell counter `cnt`, width $clog2(HOLD_COUNT+1). It increments each OWNED cycle and saturates at HOLD_COUNT.
  - Round-robin pointer `last`, the most recent owner.
- Round-robin winner search order from pointer p: p+1, p+2, p (mod 3). The first set request bit wins.
- IDLE:
  - `grant`=0 and displays=IDLE_VALUE.
  - If `req`!=0: grant the winner searching from `last`, `cnt`<=0, go to OWNED.
- OWNED with owner k, evaluated in priority order:
  1. `req[k]`==0 (voluntary release):
     - If another request is pending, grant the winner searching from k, `cnt`<=0.
     - Otherwise `grant`<=0 and go to IDLE.
     - The dwell time is not enforced on release.
  2. `cnt`==HOLD_COUNT and `req & ~grant` != 0 (preemption): grant the winner searching from k (this excludes k), `cnt`<=0.
  3. Otherwise keep k; `cnt` increments with saturation.
- On every ownership change, `last`<=new owner. `last` is not updated on a transition to IDLE.
- Handoff has no gap: `grant` moves directly between requesters without an idle cycle.
- Display path:
  - Each edge, {displayA..D} <= data of the next-state owner, or IDLE_VALUE if the next state is IDLE.
  - Displays therefore track the owner's live data with 1-cycle latency.
  - Non-owner data is ignored.
- `busy` <= (next grant != 0).
- `grant` is always one-hot or zero; no other value is legal.

## Timing
- Reset (`reset_n`=0 at an edge), including mid-ownership:
  - `grant`=0, `busy`=0, displays=IDLE_VALUE, `cnt`=0, `last`=2 (so requester 0 has first priority), state IDLE.
  - `req` is ignored during reset. Arbitration resumes on the first edge with `reset_n`=1.
- Request to grant: 1 clock. A `req` seen at edge n gives `grant` and displays valid after edge n.
- Earliest preemption: at the edge where `cnt`==HOLD_COUNT, i.e. HOLD_COUNT+1 edges after the grant edge. The new grant and new display data appear after that edge.
- Release to regrant: 1 clock. Owner `req` low at edge n gives the new owner, or IDLE, after edge n.
- A lone requester holds indefinitely; `cnt` stays saturated. A later competing request preempts at the first edge it is seen.
- Simultaneous release and new request at the same edge: the handoff goes to the new requester that edge (rule 1).
- All three requesting continuously: ownership rotates 0→1→2→0, each owner holding HOLD_COUNT+1 cycles.

## Test plan
(HOLD_COUNT=4, IDLE_VALUE=16'hFFFF)
- Reset with `req`=3'b111 held: `grant`=0, displays=F,F,F,F. On the first edge after release: `grant`=3'b001, displays = `data0` nibbles.
- `req`=3'b010 alone, `data1`=16'h1234, then change `data1` to 16'h5678 mid-ownership: `grant`=3'b010, display shows 1,2,3,4, then 5,6,7,8 one clock later. `grant` is held for 20+ cycles.
- Owner 0 granted; raise `req[2]` on cycle 1: `grant` stays 3'b001 until the cycle-5 edge, then becomes 3'b100 with displays = `data2`.
- Owner 1 drops `req` on cycle 2 with `req[0]` pending: `grant`=3'b001 on the next edge, with no IDLE cycle. If nothing is pending: `grant`=0 and displays=FFFF the next edge.
- `req`=3'b111 constant for 20 cycles: `grant` sequence 001×5, 010×5, 100×5, 001×5.
- Assert `reset_n`=0 for one edge while owner 2 is mid-dwell: `grant`=0 and displays=FFFF immediately. Afterwards, with `req`=3'b101, requester 0 wins.
